ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
Parametrised, clocked successor to the combinational 16-bit add/multiply ULA. It supports add, subtract and unsigned multiply over WIDTH-bit operands, with an overflow flag for every operation. Operations are started with a start/ready handshake and reported with a one-cycle done pulse. Add/sub complete in 1 cycle; multiply uses an iterative shift-add datapath that completes in WIDTH+1 cycles. It sits between the register-file operand path and the result writeback.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
op  input  2  operation: 00 add, 01 sub, 10 mul, 11 reserved
A  input  WIDTH  operand A, sampled at accept
B  input  WIDTH  operand B, sampled at accept
ready  output  1  1 when idle and able to accept start
busy  output  1  1 while a multiply is iterating (always equals !ready)
done  output  1  one-cycle pulse: C/overflow updated this cycle
C  output  WIDTH  result
overflow  output  1  overflow of the completed operation

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; ready=1, busy=0, done=0, C=0, overflow=0. Reset overrides start and aborts any multiply in progress; no done is produced for an aborted op.
- Accept: start=1 and ready=1 at edge t. op, A and B are latched. start while ready=0 is ignored (no queueing).
- States: IDLE and MUL.
  - IDLE + accept of add/sub/reserved -> stays IDLE; result is registered at edge t; done=1 during cycle t+1.
  - IDLE + accept of mul -> MUL with iteration counter=0.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the final step, the state returns to IDLE, C/overflow are registered and done=1 in the following cycle. Multiply accepted at edge t therefore gives done during cycle t+WIDTH+1.
- Back-to-back operation: done is asserted while in IDLE, so a new start is accepted in the same cycle as done. Add/sub can therefore issue every cycle.
- Arithmetic (all unsigned):
  - add: C = (A+B) mod 2^WIDTH; overflow = carry out.
  - sub: C = (A-B) mod 2^WIDTH; overflow = borrow (A<B).
  - mul: 2*WIDTH-bit product P; C = P[WIDTH-1:0]; overflow = |P[2*WIDTH-1:WIDTH].
  - reserved (11): C=0, overflow=0, 1-cycle latency with done.
- Hold: C and overflow hold their last values between done pulses. Inputs are don't-care after accept.
- done is never asserted for two consecutive cycles from a single op. done is 0 during all MUL cycles except as defined above.

Decomposition:
- Shared package ula_pkg:
  - op codes: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_RSV=2'b11
  - state encodings: S_IDLE, S_MUL
- One natural sub-module: mult_seq. It is the WIDTH-cycle shift-add unsigned multiplier with its own load/step/counter. It takes A and B at load and outputs the 2*WIDTH-bit product and a last-step flag.
- The add/sub path and the FSM stay in ula_seq.

Test Plan:
All cases use WIDTH=16.
1. add A=0x7FFF, B=0x0001, start at edge t -> done during t+1, C=0x8000, overflow=0. Then add 0xFFFF+0x0002 -> C=0x0001, overflow=1.
2. sub A=0x0003, B=0x0005 -> C=0xFFFE, overflow=1. sub 0x0005-0x0003 -> C=0x0002, overflow=0.
3. mul A=0x00FF, B=0x0101 at edge t -> ready=0 for cycles t+1..t+16, done during t+17, C=0xFFFF, overflow=0. mul 0x0100*0x0100 -> C=0x0000, overflow=1.
4. During a mul, pulse start with op=add, A=1, B=1 at cycle t+5 -> ignored: only one done (at t+17) with the mul result.
5. Reset mid-multiply: rst=1 at edge t+8 -> next cycle ready=1, C=0, overflow=0; no done for 20 cycles after. A new add 2+3 then returns C=0x0005.
6. Back-to-back adds: start=1 every cycle with (1+1), (2+2), (3+3) -> done on three consecutive cycles with C=0x0002, 0x0004, 0x0006.

Source files
------------

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared opcodes and FSM state encoding for the sequential ULA
package ula_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - WIDTH-step shift-add unsigned multiplier with load/step control
module mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 last_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Product register holds {partial_sum, remaining multiplier bits}; the
  // multiplier is consumed from bit 0 and shifted out as the sum shifts in.
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] step_val;

  // One shift-add step: conditionally add the multiplicand to the upper half,
  // then shift the whole register right by one keeping the carry.
  always_comb begin
    addend   = prod_q[0] ? mcand_q : '0;
    partial  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    step_val = {partial, prod_q[WIDTH-1:1]};

    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      mcand_d = a_i;
      prod_d  = {{WIDTH{1'b0}}, b_i};
      cnt_d   = '0;
    end else if (step_i) begin
      prod_d = step_val;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // The product is presented combinationally so the caller can register it
  // on the same edge that performs the final step.
  assign product_o = step_val;
  assign last_o    = step_i && !load_i && (cnt_q == CW'(WIDTH - 1));

  // Datapath and step counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - clocked add/sub/mul ULA with start/ready handshake and done pulse
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             overflow
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic               mul_load;
  logic               mul_step;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_last;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;

  // Extended add/sub expose carry-out and borrow in the top bit.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};

  mult_seq #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .load_i   (mul_load),
    .step_i   (mul_step),
    .a_i      (A),
    .b_i      (B),
    .product_o(mul_product),
    .last_o   (mul_last)
  );

  // Next-state, result and done logic; C/overflow hold unless an op completes.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD: begin
              c_d    = sum_ext[WIDTH-1:0];
              ovf_d  = sum_ext[WIDTH];
              done_d = 1'b1;
            end
            OP_SUB: begin
              c_d    = diff_ext[WIDTH-1:0];
              ovf_d  = diff_ext[WIDTH];
              done_d = 1'b1;
            end
            OP_MUL: begin
              mul_load = 1'b1;
              state_d  = S_MUL;
            end
            default: begin
              c_d    = '0;
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          c_d     = mul_product[WIDTH-1:0];
          ovf_d   = |mul_product[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any multiply without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = !ready;
  assign done     = done_q;
  assign C        = c_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - self-checking bench for ula_seq: vector table, corner sequences, random vs model
module tb_ula_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         ready, busy, done, overflow;
  logic [W-1:0] C;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .C       (C),
    .overflow(overflow)
  );

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] c, output logic ov, output int lat);
    longint unsigned m, x, y, r;
    m = 64'd1 << W;
    x = a;
    y = b;
    c = '0;
    ov = 1'b0;
    lat = 1;
    case (o)
      2'd0: begin r = x + y; c = W'(r % m); ov = (r >= m); end
      2'd1: begin r = (x + m - y) % m; c = W'(r); ov = (x < y); end
      2'd2: begin r = x * y; c = W'(r % m); ov = (r >= m); lat = W + 1; end
      default: ;
    endcase
  endfunction

  // Called at a negedge; issues one op and waits (bounded) for its done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ec, input logic eov, input int elat, input string tag);
    int   cyc;
    logic busy_ok;
    op = o; A = a; B = b; start = 1'b1;
    cyc = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (!done && !(busy && !ready)) busy_ok = 1'b0;
    end while (!done && cyc < 40);
    check({tag, " latency"}, cyc, elat);
    check({tag, " C"}, C, ec);
    check({tag, " overflow"}, overflow, eov);
    check({tag, " ready_at_done"}, ready, 1);
    if (elat > 1) check({tag, " busy_while_mul"}, busy_ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ec;
    logic         eov;
    int           elat;
    int           ndone;
    int           dcyc;
    logic [W-1:0] dc;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    vecs.push_back('{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1});
    vecs.push_back('{2'b00, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1});
    vecs.push_back('{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1});
    vecs.push_back('{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1});
    vecs.push_back('{2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1});
    vecs.push_back('{2'b01, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1});
    vecs.push_back('{2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1});
    vecs.push_back('{2'b10, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 17});
    vecs.push_back('{2'b10, 16'h0100, 16'h0100, 16'h0000, 1'b1, 17});
    vecs.push_back('{2'b10, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 17});
    vecs.push_back('{2'b10, 16'h0000, 16'h1234, 16'h0000, 1'b0, 17});
    vecs.push_back('{2'b11, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1});
    vecs.push_back('{2'b10, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 17});
    vecs.push_back('{2'b00, 16'h0ABC, 16'h0001, 16'h0ABD, 1'b0, 1});

    // Reset state
    repeat (2) @(negedge clk);
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset C", C, 0);
    check("reset overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ov, vecs[i].lat, $sformatf("vec%0d", i));

    // Single-cycle done pulse and result hold
    @(negedge clk);
    check("done single pulse", done, 0);
    repeat (3) @(negedge clk);
    check("hold C", C, 16'h0ABD);
    check("hold overflow", overflow, 0);

    // Start during multiply is ignored
    op = 2'b10; A = 16'h00FF; B = 16'h0101; start = 1'b1;
    ndone = 0; dcyc = 0; dc = '0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 5) begin op = 2'b00; A = 16'd1; B = 16'd1; start = 1'b1; end
      if (done) begin ndone++; dcyc = cyc; dc = C; end
    end
    check("ignored start done count", ndone, 1);
    check("ignored start done cycle", dcyc, 17);
    check("ignored start C", dc, 16'hFFFF);

    // Reset mid-multiply
    op = 2'b10; A = 16'h1234; B = 16'h0010; start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 8) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("abort ready", ready, 1);
    check("abort busy", busy, 0);
    check("abort C", C, 0);
    check("abort overflow", overflow, 0);
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);
    run_op(2'b00, 16'd2, 16'd3, 16'h0005, 1'b0, 1, "post-abort add");

    // Back-to-back adds
    op = 2'b00; A = 16'd1; B = 16'd1; start = 1'b1;
    @(negedge clk);
    check("b2b done1", done, 1);
    check("b2b C1", C, 16'h0002);
    A = 16'd2; B = 16'd2;
    @(negedge clk);
    check("b2b done2", done, 1);
    check("b2b C2", C, 16'h0004);
    A = 16'd3; B = 16'd3;
    @(negedge clk);
    check("b2b done3", done, 1);
    check("b2b C3", C, 16'h0006);
    start = 1'b0;
    @(negedge clk);
    check("b2b done end", done, 0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) ra = '1;
      if (i % 8 == 1) rb = '0;
      model(ro, ra, rb, ec, eov, elat);
      run_op(ro, ra, rb, ec, eov, elat, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
